// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: lock FSM encoding,
// default geometry and the fixed requester slot assignment.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    COOLDOWN = 2'd2
  } lock_state_t;

  localparam int DEF_N_REQ        = 3;
  localparam int DEF_AW           = 8;
  localparam int DEF_DW           = 8;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_LOCK_MAX     = 8;

  localparam int REQ_DBG   = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_FETCH = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Lowest-index find-first-set over a request mask; returns one-hot, index and
// an any-set flag. Purely combinational.
module mem_arb_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_mask,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scanning downwards lets the lowest set index overwrite any higher one.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
        o_idx       = IW'(i);
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fixed priority with starvation escalation and a
// bounded bus lock. Grant is combinational, read-valid is registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int LOCK_MAX     = DEF_LOCK_MAX
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ-1:0]         i_we,
  input  logic [N_REQ-1:0]         i_lock,
  input  logic [N_REQ-1:0][AW-1:0] i_addr,
  input  logic [N_REQ-1:0][DW-1:0] i_wdata,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_rvalid,
  output logic [DW-1:0]            o_rdata,
  output logic                     o_mem_en,
  output logic                     o_mem_we,
  output logic [AW-1:0]            o_mem_addr,
  output logic [DW-1:0]            o_mem_wdata,
  input  logic [DW-1:0]            i_mem_rdata
);

  localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WCW = $clog2(STARVE_LIMIT + 1);
  localparam int LCW = $clog2(LOCK_MAX + 1);

  lock_state_t    r_state, w_state_next;
  logic [IW-1:0]  r_owner, w_owner_next;
  logic [LCW-1:0] r_lock_cnt, w_lock_cnt_next;
  logic [WCW-1:0] r_wait_cnt [N_REQ];
  logic [N_REQ-1:0] r_rvalid;

  logic [N_REQ-1:0] w_owner_mask, w_eligible, w_starved;
  logic [N_REQ-1:0] w_starve_oh, w_plain_oh, w_gnt;
  logic [IW-1:0]    w_starve_idx, w_plain_idx, w_win_idx;
  logic             w_starve_any, w_plain_any, w_lock_hold, w_any;

  // The previous owner sits out the single COOLDOWN cycle.
  assign w_owner_mask = (r_state == COOLDOWN) ? (N_REQ'(1) << r_owner) : '0;
  assign w_eligible   = i_req & ~w_owner_mask;
  assign w_lock_hold  = (r_state == LOCKED) && i_req[r_owner] && i_lock[r_owner];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_starved
    assign w_starved[gi] = w_eligible[gi] && (r_wait_cnt[gi] == WCW'(STARVE_LIMIT));
  end

  mem_arb_pick #(.N(N_REQ), .IW(IW)) u_pick_starved (
    .i_mask   (w_starved),
    .o_onehot (w_starve_oh),
    .o_idx    (w_starve_idx),
    .o_any    (w_starve_any)
  );

  mem_arb_pick #(.N(N_REQ), .IW(IW)) u_pick_plain (
    .i_mask   (w_eligible),
    .o_onehot (w_plain_oh),
    .o_idx    (w_plain_idx),
    .o_any    (w_plain_any)
  );

  // Reset gates the grant combinationally so nothing reaches memory while low.
  always_comb begin
    w_gnt     = '0;
    w_win_idx = '0;
    w_any     = 1'b0;
    if (!i_rst_n) begin
      w_any = 1'b0;
    end else if (w_lock_hold) begin
      w_gnt[r_owner] = 1'b1;
      w_win_idx      = r_owner;
      w_any          = 1'b1;
    end else if (w_starve_any) begin
      w_gnt     = w_starve_oh;
      w_win_idx = w_starve_idx;
      w_any     = 1'b1;
    end else if (w_plain_any) begin
      w_gnt     = w_plain_oh;
      w_win_idx = w_plain_idx;
      w_any     = 1'b1;
    end
  end

  assign o_gnt       = w_gnt;
  assign o_mem_en    = w_any;
  assign o_mem_we    = w_any && i_we[w_win_idx];
  assign o_mem_addr  = w_any ? i_addr[w_win_idx] : '0;
  assign o_mem_wdata = w_any ? i_wdata[w_win_idx] : '0;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = i_mem_rdata;

  // A dropped lock falls through to normal arbitration, which may relock.
  always_comb begin
    w_state_next    = r_state;
    w_owner_next    = r_owner;
    w_lock_cnt_next = r_lock_cnt;
    case (r_state)
      COOLDOWN: begin
        w_state_next    = UNLOCKED;
        w_lock_cnt_next = '0;
      end
      default: begin
        if (w_lock_hold) begin
          w_lock_cnt_next = r_lock_cnt + LCW'(1);
          w_state_next    = (int'(r_lock_cnt) + 1 >= LOCK_MAX) ? COOLDOWN : LOCKED;
        end else if (w_any && i_lock[w_win_idx]) begin
          w_owner_next    = w_win_idx;
          w_lock_cnt_next = LCW'(1);
          w_state_next    = (LOCK_MAX <= 1) ? COOLDOWN : LOCKED;
        end else begin
          w_state_next    = UNLOCKED;
          w_lock_cnt_next = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= UNLOCKED;
      r_owner    <= '0;
      r_lock_cnt <= '0;
      r_rvalid   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_owner    <= w_owner_next;
      r_lock_cnt <= w_lock_cnt_next;
      r_rvalid   <= w_gnt & ~i_we;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_wait
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_wait_cnt[gi] <= '0;
      end else if (!i_req[gi] || w_gnt[gi]) begin
        r_wait_cnt[gi] <= '0;
      end else if (r_wait_cnt[gi] != WCW'(STARVE_LIMIT)) begin
        r_wait_cnt[gi] <= r_wait_cnt[gi] + WCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus hand sequences for starvation,
// lock bound and reset, with a read-data scoreboard against a shadow memory.
module tb_mem_arbiter;

  logic             clk;
  logic             rst_n;
  logic [2:0]       req, we, lock;
  logic [2:0][7:0]  addr, wdata;
  logic [2:0]       gnt, rvalid;
  logic [7:0]       rdata, mem_addr, mem_wdata, mem_rdata;
  logic             mem_en, mem_we;
  logic             mem_init;

  logic [7:0] env_mem [256];
  logic [7:0] shadow  [256];

  typedef struct {
    logic [1:0] idx;
    logic [7:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [2:0]      req;
    logic [2:0]      we;
    logic [2:0]      lock;
    logic [2:0][7:0] addr;
    logic [2:0][7:0] wdata;
    logic [2:0]      gnt;
  } vec_t;
  vec_t vecs[14];

  int n_cmp;
  int n_bad;

  mem_arbiter dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_we        (we),
    .i_lock      (lock),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_mem_en    (mem_en),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    case (a)
      8'h10:   return 8'h5A;
      8'h00:   return 8'hC0;
      8'h01:   return 8'hC1;
      8'h02:   return 8'hC2;
      default: return a ^ 8'h96;
    endcase
  endfunction

  // Synchronous memory macro model driven only by the arbiter's memory port.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_val(8'(i));
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [2:0] g);
    if (g[0]) return 2'd0;
    if (g[1]) return 2'd1;
    return 2'd2;
  endfunction

  task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                       input logic [23:0] a, input logic [23:0] d);
    req   = r;
    we    = w;
    lock  = l;
    addr  = a;
    wdata = d;
  endtask

  // One cycle: inputs already driven; check at the falling edge, then advance.
  task automatic run_cycle(input logic [2:0] exp_gnt, input string tag);
    sb_t        e;
    logic [1:0] w;
    logic [2:0] exp_rv;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e      = sb_q.pop_front();
      exp_rv = 3'b001 << e.idx;
      chk({tag, " rdata"}, 32'(rdata), 32'(e.data));
    end else begin
      exp_rv = 3'b000;
    end
    chk({tag, " rvalid"}, 32'(rvalid), 32'(exp_rv));
    chk({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    if (exp_gnt != 3'b000) begin
      w = oh2idx(exp_gnt);
      chk({tag, " mem_en"}, 32'(mem_en), 32'd1);
      chk({tag, " mem_we"}, 32'(mem_we), 32'(we[w]));
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(addr[w]));
      chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(wdata[w]));
      if (we[w]) shadow[addr[w]] = wdata[w];
      else       sb_q.push_back('{w, shadow[addr[w]]});
    end else begin
      chk({tag, " mem_en"}, 32'(mem_en), 32'd0);
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    end
    $display("cycle %s: req=%b we=%b lock=%b gnt=%b rvalid=%b rdata=%h",
             tag, req, we, lock, gnt, rvalid, rdata);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    run_cycle(3'b000, tag);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));

    //              req     we      lock    addr{2,1,0}   wdata{2,1,0}  gnt
    vecs[0]  = '{3'b100, 3'b000, 3'b000, 24'h10_00_00, 24'h00_00_00, 3'b100};
    vecs[1]  = '{3'b010, 3'b010, 3'b000, 24'h00_FF_00, 24'h00_A5_00, 3'b010};
    vecs[2]  = '{3'b010, 3'b000, 3'b000, 24'h00_FF_00, 24'h00_00_00, 3'b010};
    vecs[3]  = '{3'b000, 3'b000, 3'b000, 24'h00_00_00, 24'h00_00_00, 3'b000};
    vecs[4]  = '{3'b111, 3'b000, 3'b000, 24'h22_21_20, 24'h00_00_00, 3'b001};
    vecs[5]  = '{3'b110, 3'b000, 3'b000, 24'h22_21_20, 24'h00_00_00, 3'b010};
    vecs[6]  = '{3'b000, 3'b000, 3'b000, 24'h00_00_00, 24'h00_00_00, 3'b000};
    vecs[7]  = '{3'b101, 3'b001, 3'b000, 24'h31_00_30, 24'h00_00_3C, 3'b001};
    vecs[8]  = '{3'b100, 3'b000, 3'b000, 24'h30_00_00, 24'h00_00_00, 3'b100};
    vecs[9]  = '{3'b011, 3'b011, 3'b000, 24'h00_41_40, 24'h00_22_11, 3'b001};
    vecs[10] = '{3'b010, 3'b010, 3'b000, 24'h00_41_00, 24'h00_22_00, 3'b010};
    vecs[11] = '{3'b010, 3'b000, 3'b000, 24'h00_41_00, 24'h00_00_00, 3'b010};
    vecs[12] = '{3'b001, 3'b000, 3'b000, 24'h00_00_40, 24'h00_00_00, 3'b001};
    vecs[13] = '{3'b000, 3'b000, 3'b000, 24'h00_00_00, 24'h00_00_00, 3'b000};

    // Reset with every requester asserted: nothing may be granted.
    rst_n    = 1'b0;
    mem_init = 1'b1;
    drive(3'b111, 3'b000, 3'b000, 24'h01_02_03, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset rvalid", 32'(rvalid), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    mem_init = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 14; v++) begin
      drive(vecs[v].req, vecs[v].we, vecs[v].lock, vecs[v].addr, vecs[v].wdata);
      run_cycle(vecs[v].gnt, $sformatf("vec%0d", v));
    end

    // Back-to-back fetches of 0x00..0x02.
    for (int c = 0; c < 3; c++) begin
      drive(3'b100, 3'b000, 3'b000, {8'(c), 16'h0}, 24'h0);
      run_cycle(3'b100, $sformatf("fetch%0d", c));
    end
    idle("fetch_drain0");
    idle("fetch_drain1");

    // Starvation: requester 2 escalates after four lost cycles.
    for (int c = 0; c < 10; c++) begin
      drive(3'b101, 3'b000, 3'b000, 24'h52_00_50, 24'h0);
      run_cycle((c == 4 || c == 9) ? 3'b100 : 3'b001, $sformatf("starve%0d", c));
    end
    idle("starve_drain0");
    idle("starve_drain1");

    // Lock bound: eight locked grants, cooldown hands the bus to requester 0.
    for (int c = 0; c < 10; c++) begin
      drive((c < 2) ? 3'b010 : 3'b011, 3'b000, 3'b010, 24'h00_60_61, 24'h0);
      run_cycle((c < 8) ? 3'b010 : 3'b001, $sformatf("lock%0d", c));
    end
    idle("lock_drain0");
    idle("lock_drain1");

    // Reset while locked with a read in flight and a waiter pending.
    drive(3'b100, 3'b000, 3'b100, 24'h10_00_00, 24'h0);
    run_cycle(3'b100, "rst_pre0");
    drive(3'b101, 3'b000, 3'b100, 24'h10_00_77, 24'h0);
    run_cycle(3'b100, "rst_pre1");
    rst_n = 1'b0;
    #1;
    chk("midreset rvalid", 32'(rvalid), 32'd0);
    chk("midreset gnt", 32'(gnt), 32'd0);
    chk("midreset mem_en", 32'(mem_en), 32'd0);
    chk("midreset mem_we", 32'(mem_we), 32'd0);
    sb_q.delete();
    @(negedge clk);
    drive(3'b000, 3'b000, 3'b000, 24'h0, 24'h0);
    rst_n = 1'b1;
    #1;
    chk("post-reset lock state", 32'(dut.r_state), 32'd0);
    chk("post-reset owner", 32'(dut.r_owner), 32'd0);
    chk("post-reset lock_cnt", 32'(dut.r_lock_cnt), 32'd0);
    for (int i = 0; i < 3; i++)
      chk($sformatf("post-reset wait_cnt%0d", i), 32'(dut.r_wait_cnt[i]), 32'd0);
    @(posedge clk);
    #1;
    idle("post_reset_idle");
    drive(3'b101, 3'b000, 3'b000, 24'h10_00_12, 24'h0);
    run_cycle(3'b001, "post_reset_arb");
    idle("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the CPU's single-port 256x8 synchronous memory between N requesters: debug loader (index 0), CPU data port (1), CPU instruction fetch (2). Fixed-priority arbitration with starvation escalation and bounded bus locking. One access per cycle, combinational grant, registered read-valid. Sits between cpu and the memory macro.

Parameters:
N_REQ, 3, number of requesters; index 0 has the highest base priority.
AW, 8, address width.
DW, 8, data width.
STARVE_LIMIT, 4, consecutive lost cycles after which a requester is escalated.
LOCK_MAX, 8, maximum consecutive granted cycles under lock.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req  in  N_REQ  access request per requester; held until gnt.
we  in  N_REQ  1=write, 0=read, per requester.
lock  in  N_REQ  request to keep the bus after grant.
addr  in  N_REQ x AW  per-requester address (packed array).
wdata  in  N_REQ x DW  per-requester write data.
gnt  out  N_REQ  one-hot, combinational; access accepted this cycle.
rvalid  out  N_REQ  registered; read data valid, one cycle after a read grant.
rdata  out  DW  shared read data; meaningful only with an rvalid bit.
mem_en  out  1  memory access this cycle.
mem_we  out  1  memory write enable.
mem_addr  out  AW  memory address.
mem_wdata  out  DW  memory write data.
mem_rdata  in  DW  memory read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset low: gnt=0, mem_en=0, mem_we=0 immediately (combinational gating). rvalid=0, wait counters=0, lock FSM=UNLOCKED, owner=0 asynchronously. mem_addr and mem_wdata=0.
- Winner priority each cycle, first match wins:
  (a) LOCKED and req[owner] and lock[owner] -> owner.
  (b) Lowest-index requester with req=1 and wait_cnt==STARVE_LIMIT.
  (c) Lowest-index requester with req=1.
- In COOLDOWN, the previous owner is masked from (b) and (c) for exactly one cycle.
- Granted cycle: gnt[w]=1, mem_en=1, mem_we=we[w], mem_addr=addr[w], mem_wdata=wdata[w]. No requester: everything 0.
- Grant handshake:
  - A requester drops req or changes addr in the cycle after it sees gnt.
  - A new request in that following cycle is a new access, so back-to-back grants give one access per cycle.
- Reads: rvalid[w] is registered gnt[w] & ~we[w]; rdata = mem_rdata (passthrough). Read latency is exactly 1 cycle. Writes never raise rvalid.
- wait_cnt[i] (width clog2(STARVE_LIMIT+1)):
  - +1 on each cycle with req[i]=1 and gnt[i]=0.
  - Saturates at STARVE_LIMIT.
  - Cleared on gnt[i] or req[i]=0.
- Lock FSM:
  - UNLOCKED -> LOCKED on a grant with lock[w]=1. Register owner=w, lock_cnt=1.
  - LOCKED, grant to owner -> lock_cnt+1.
  - LOCKED -> UNLOCKED when req[owner]=0 or lock[owner]=0. Normal arbitration applies that same cycle.
  - LOCKED -> COOLDOWN on the granted cycle where lock_cnt reaches LOCK_MAX.
  - COOLDOWN -> UNLOCKED after 1 cycle; the owner is masked during it.
- Lock overrides starvation; LOCK_MAX bounds the worst-case wait.
- Simultaneous reset and grant: reset wins; no rvalid in the following cycle.
- Address wrap is the requester's concern; the arbiter passes AW bits unchanged.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {UNLOCKED, LOCKED, COOLDOWN} lock_state_t;
  - default parameter constants;
  - requester index constants REQ_DBG=0, REQ_DATA=1, REQ_FETCH=2.
- One sub-module, mem_arb_pick: combinational lowest-index find-first-set over an N_REQ mask, returning one-hot and index. Instantiated twice: starved mask and plain mask.

Test Plan:
1. Read 0x10 from requester 2, memory holds 0x5A: req[2]=1, addr=0x10 -> gnt[2]=1 and mem_addr=0x10 the same cycle; rvalid[2]=1 with rdata=0x5A the next cycle.
2. Write then read, requester 1: we=1, addr=0xFF, wdata=0xA5 -> mem_we=1 and no rvalid. A read of 0xFF next cycle -> rvalid[1] with rdata=0xA5 one cycle later.
3. Starvation: req[0] and req[2] held continuously -> gnt[0] on cycles 0-3, gnt[2] on cycle 4, gnt[0] on cycles 5-8, gnt[2] on cycle 9.
4. Lock bound: req[1]+lock[1] alone at cycle 0, req[0] from cycle 2 -> gnt[1] on cycles 0-7, COOLDOWN with gnt[0] on cycle 8, normal priority from cycle 9.
5. Back-to-back fetch of 0x00, 0x01, 0x02 on consecutive cycles -> three consecutive gnt[2] pulses, then rvalid[2] on three consecutive cycles with the matching data.
6. Reset mid-operation: read granted at cycle N, reset low at the start of cycle N+1 -> rvalid=0, gnt=0, mem_en=0 at once. The lock FSM and wait counters read 0 after release.
